// File: rtl/mdu_seq.sv
// Radix-2 iterative RV32M multiply/divide unit, one bit per cycle.
// Latency: done 34 cycles after start (WIDTH+2); 1 cycle for div-by-zero/overflow when FAST_SPEC.
// Backpressure: busy high from start+1 through done; start while busy or in DONE is dropped.
module mdu_seq #(
    parameter int WIDTH     = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             sa, sb, bz;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, dvs;

    logic             a_sgn, b_sgn, ovf, take_fast;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res;
    logic [WIDTH:0]   msum, rsh, dif;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, fix_res;

    // Operand decode for the start cycle
    always_comb begin
        a_sgn     = a[WIDTH-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        b_sgn     = b[WIDTH-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
        a_mag     = a_sgn ? -a : a;
        b_mag     = b_sgn ? -b : b;
        ovf       = (op == 3'b100 || op == 3'b110) && (a == MIN_VAL) && (b == '1);
        take_fast = FAST_SPEC && op[2] && ((b == '0) || ovf);
        fast_res  = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_VAL);
    end

    // Datapath step and final sign fix-up
    always_comb begin
        msum    = {1'b0, hi} + {1'b0, (lo[0] ? dvs : {WIDTH{1'b0}})};
        rsh     = {hi, lo[WIDTH-1]};
        dif     = rsh - {1'b0, dvs};
        prod    = {hi, lo};
        prod_s  = (sa ^ sb) ? -prod : prod;
        // A zero divisor keeps the all-ones quotient regardless of the dividend sign
        quo_s   = ((sa ^ sb) && !bz) ? -lo : lo;
        rem_s   = sa ? -hi : hi;
        fix_res = prod_s[WIDTH-1:0];
        if (op_q[2])
            fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] != 2'b00)
            fix_res = prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bz     <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            dvs    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        sa   <= a_sgn;
                        sb   <= b_sgn;
                        bz   <= (b == '0);
                        cnt  <= CW'(WIDTH - 1);
                        hi   <= '0;
                        lo   <= op[2] ? a_mag : b_mag;
                        dvs  <= op[2] ? b_mag : a_mag;
                        busy <= 1'b1;
                        if (take_fast) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        // Restoring step: keep the difference only when no borrow
                        if (!dif[WIDTH]) begin
                            hi <= dif[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= rsh[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi <= msum[WIDTH:1];
                        lo <= {msum[0], lo[WIDTH-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table run on a FAST_SPEC and a slow-path instance,
// plus ignored-start and mid-operation reset sequences.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset, start_f, start_s;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy_f, done_f, busy_s, done_s;
    logic [31:0] result_f, result_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_q[$];

    mdu_seq #(.WIDTH(32), .FAST_SPEC(1'b1)) dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .op(op), .a(a), .b(b),
        .busy(busy_f), .done(done_f), .result(result_f));

    mdu_seq #(.WIDTH(32), .FAST_SPEC(1'b0)) dut_slow (
        .clk(clk), .reset(reset), .start(start_s), .op(op), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .result(result_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // One operation on the selected instance; expected value goes through the queue
    task automatic run_op(input bit fs, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] ex, input bit fast);
        int t0, lat;
        bit seen, busy_ok, stable_ok;
        logic [31:0] prev, got, want;
        @(negedge clk);
        prev = fs ? result_f : result_s;
        op = o; a = va; b = vb;
        if (fs) start_f = 1'b1; else start_s = 1'b1;
        t0 = cyc;
        exp_q.push_back(ex);
        @(negedge clk);
        start_f = 1'b0; start_s = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        seen = 0; busy_ok = 1; stable_ok = 1; lat = 0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (!(fs ? busy_f : busy_s)) busy_ok = 0;
            if (fs ? done_f : done_s) begin
                seen = 1;
                lat = cyc - t0;
                break;
            end
            if ((fs ? result_f : result_s) !== prev) stable_ok = 0;
        end
        want = exp_q.pop_front();
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout op=%0d a=0x%08h b=0x%08h: no done within 60 cycles", o, va, vb);
        end else begin
            got = fs ? result_f : result_s;
            chk($sformatf("result op=%0d fast=%0d a=%08h b=%08h", o, fs, va, vb), got, want);
            chk($sformatf("latency op=%0d fast=%0d", o, fs), 32'(lat), (fs && fast) ? 32'd1 : 32'd34);
            chk("busy through op", {31'd0, busy_ok}, 32'd1);
            chk("result stable while busy", {31'd0, stable_ok}, 32'd1);
            @(negedge clk);
            chk("busy low after done", {31'd0, fs ? busy_f : busy_s}, 32'd0);
        end
    endtask

    initial begin
        int t0;
        bit extra_done;
        reset = 1'b1; start_f = 0; start_s = 0; op = 0; a = 0; b = 0;

        vecs[0]  = '{3'b000, 32'd7,        32'd6,        32'h0000002A, 0};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0};
        vecs[6]  = '{3'b101, 32'd7,        32'd2,        32'h00000003, 0};
        vecs[7]  = '{3'b111, 32'd7,        32'd2,        32'h00000001, 0};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'h00000005, 1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
        vecs[14] = '{3'b111, 32'd5,        32'd0,        32'h00000005, 1};
        vecs[15] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
        vecs[16] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
        vecs[17] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0};
        vecs[18] = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0};
        vecs[19] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0};
        vecs[20] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 0};
        vecs[21] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0};

        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy_f}, 32'd0);
        chk("reset done", {31'd0, done_f}, 32'd0);
        chk("reset result", result_f, 32'd0);
        chk("reset result slow", result_s, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);
        end

        // Start while busy and start during DONE are both dropped
        @(negedge clk);
        op = 3'b000; a = 32'd7; b = 32'd6; start_f = 1'b1; t0 = cyc;
        @(negedge clk); start_f = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'b101; a = 32'd100; b = 32'd3; start_f = 1'b1;
        @(negedge clk); start_f = 1'b0;
        while (!done_f && (cyc - t0) < 60) @(negedge clk);
        chk("ignored start: done cycle", 32'(cyc - t0), 32'd34);
        chk("ignored start: result", result_f, 32'h0000002A);
        start_f = 1'b1; op = 3'b101; a = 32'd9; b = 32'd0;
        @(negedge clk); start_f = 1'b0;
        chk("start in DONE: busy", {31'd0, busy_f}, 32'd0);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_f || busy_f) extra_done = 1;
        end
        chk("no queued op", {31'd0, extra_done}, 32'd0);
        chk("result held", result_f, 32'h0000002A);

        // Reset in the middle of CALC aborts without a done pulse
        op = 3'b000; a = 32'd3; b = 32'd4; start_f = 1'b1; t0 = cyc;
        @(negedge clk); start_f = 1'b0;
        while ((cyc - t0) < 10) @(negedge clk);
        chk("busy before abort", {31'd0, busy_f}, 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("abort busy", {31'd0, busy_f}, 32'd0);
        chk("abort result", result_f, 32'd0);
        extra_done = done_f;
        repeat (30) begin
            @(negedge clk);
            if (done_f) extra_done = 1;
        end
        chk("abort no done", {31'd0, extra_done}, 32'd0);
        run_op(1'b1, 3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
